// File: rtl/div_ctrl_pkg.sv
// Shared constants, types and helpers for the multi-cycle divide sequencer.
// State codes, handshake levels and decoder op codes all live here.
package div_ctrl_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // SPECIAL-class function codes and the ALU ops the decoder emits for them
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] hi;
        logic [DIV_WIDTH-1:0] lo;
    } div_result_t;

    function automatic logic [DIV_WIDTH-1:0] div_neg(input logic [DIV_WIDTH-1:0] x);
        return ~x + DIV_WIDTH'(1);
    endfunction

    // Most negative value maps to itself, read back as unsigned 2^(W-1)
    function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] x,
                                                     input logic is_signed);
        return (is_signed && x[DIV_WIDTH-1]) ? div_neg(x) : x;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider handshake: request operands in, {HI,LO} result and stall out.
interface div_ctrl_if;
    import div_ctrl_pkg::*;

    logic                   start_i;
    logic                   signed_i;
    logic                   annul_i;
    logic [DIV_WIDTH-1:0]   opdata1_i;
    logic [DIV_WIDTH-1:0]   opdata2_i;
    logic [2*DIV_WIDTH-1:0] result_o;
    logic                   ready_o;
    logic                   stall_o;

    modport master (
        output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stall_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stall_o
    );

endinterface

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract,
// keep the difference when there is no borrow.
module div_step
    import div_ctrl_pkg::*;
#(
    parameter int unsigned W = DIV_WIDTH
) (
    input  logic [W-1:0] rem_i,
    input  logic         dvd_bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // Partial remainder stays below the divisor, so W+1 bits hold the trial exactly
    assign shifted = {rem_i, dvd_bit_i};
    assign trial   = shifted - {1'b0, divisor_i};
    assign q_bit_o = ~trial[W];
    assign rem_o   = q_bit_o ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer: 32-step restoring division over shared dividend/quotient and
// partial-remainder registers, with stall, annul and divide-by-zero handling.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input logic       clk,
    input logic       resetn,
    div_ctrl_if.slave bus
);

    localparam int unsigned W = DIV_WIDTH;

    div_state_e             state_q,    state_d;
    logic [DIV_CNT_W-1:0]   cnt_q,      cnt_d;
    logic [W-1:0]           dvd_q,      dvd_d;
    logic [W-1:0]           dsr_q,      dsr_d;
    logic [W-1:0]           rem_q,      rem_d;
    logic                   neg_quot_q, neg_quot_d;
    logic                   neg_rem_q,  neg_rem_d;
    logic                   ready_q,    ready_d;
    logic [2*W-1:0]         result_q,   result_d;

    logic [W-1:0]           rem_next;
    logic                   q_bit;
    logic [W-1:0]           quot_raw;
    div_result_t            res_fix;

    div_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[W-1]),
        .divisor_i (dsr_q),
        .rem_o     (rem_next),
        .q_bit_o   (q_bit)
    );

    // Dividend register doubles as the quotient: MSBs shift out as quotient bits shift in
    assign quot_raw = {dvd_q[W-2:0], q_bit};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        ready_d    = ready_q;
        result_d   = result_q;
        res_fix.hi = neg_rem_q  ? div_neg(rem_next) : rem_next;
        res_fix.lo = neg_quot_q ? div_neg(quot_raw) : quot_raw;

        unique case (state_q)
            DIV_FREE: begin
                if (bus.start_i == DIV_START && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        dvd_d      = div_abs(bus.opdata1_i, bus.signed_i);
                        dsr_d      = div_abs(bus.opdata2_i, bus.signed_i);
                        rem_d      = '0;
                        neg_quot_d = bus.signed_i & (bus.opdata1_i[W-1] ^ bus.opdata2_i[W-1]);
                        neg_rem_d  = bus.signed_i & bus.opdata1_i[W-1];
                        cnt_d      = '0;
                        state_d    = DIV_ON;
                    end
                end
            end
            DIV_BYZERO: begin
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
                state_d  = DIV_END;
            end
            DIV_ON: begin
                dvd_d = quot_raw;
                rem_d = rem_next;
                cnt_d = cnt_q + DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(W - 1)) begin
                    result_d = res_fix;
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                end
            end
            DIV_END: begin
                if (bus.start_i == DIV_STOP) begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                    state_d  = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase

        // Flush wins over every in-flight transition
        if (bus.annul_i && state_q != DIV_FREE) begin
            state_d  = DIV_FREE;
            cnt_d    = '0;
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_q    <= DIV_RESULT_NOT_READY;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.result_o = result_q;
    assign bus.stall_o  = bus.start_i & ~ready_q & ~bus.annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed vector table, hand-built annul/reset sequences and
// random requests scored against an integer-arithmetic reference.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    div_ctrl_if bus();

    div_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  aluop;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Quotient truncates toward zero, remainder takes the dividend's sign
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'h0) return 64'h0;
        sa = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called at a negedge: issues the request in that cycle (cycle 0)
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int lat;
        bit done;
        bit wait_ok;
        bus.start_i   = 1'b1;
        bus.signed_i  = sgn;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        #1 check({name, " stall_c0"}, 64'(bus.stall_o), 64'd1);
        lat = 0;
        done = 1'b0;
        wait_ok = 1'b1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.ready_o) done = 1'b1;
            else if (!bus.stall_o || bus.result_o != 64'h0) wait_ok = 1'b0;
        end
        check({name, " latency"}, 64'(lat), (b == 32'h0) ? 64'd2 : 64'd33);
        check({name, " wait_stall_res0"}, 64'(wait_ok), 64'd1);
        check({name, " result"}, bus.result_o, exp);
        check({name, " stall_at_ready"}, 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        check({name, " hold_ready"}, 64'(bus.ready_o), 64'd1);
        check({name, " hold_result"}, bus.result_o, exp);
        bus.start_i = 1'b0;
        @(negedge clk);
        check({name, " clr_ready"}, 64'(bus.ready_o), 64'd0);
        check({name, " clr_result"}, bus.result_o, 64'h0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        bit          ready_seen;
        int          guard;

        vecs[0] = '{EXE_DIVU_OP, 32'd100,        32'd7,        64'h00000002_0000000E};
        vecs[1] = '{EXE_DIV_OP,  32'hFFFFFFF9,   32'h2,        64'hFFFFFFFF_FFFFFFFD};
        vecs[2] = '{EXE_DIV_OP,  32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
        vecs[3] = '{EXE_DIVU_OP, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000};
        vecs[4] = '{EXE_DIVU_OP, 32'd5,          32'd0,        64'h0};
        vecs[5] = '{EXE_DIVU_OP, 32'd9,          32'd3,        64'h00000000_00000003};
        vecs[6] = '{EXE_DIVU_OP, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF};
        vecs[7] = '{EXE_DIV_OP,  32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
        vecs[8] = '{EXE_DIV_OP,  32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E};
        vecs[9] = '{EXE_DIV_OP,  32'd5,          32'd0,        64'h0};

        resetn        = 1'b0;
        bus.start_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.annul_i   = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        #1;
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset result", bus.result_o, 64'h0);
        check("reset state", 64'(dut.state_q), 64'(DIV_FREE));
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run_div($sformatf("vec%0d", i), vecs[i].aluop == EXE_DIV_OP,
                    vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Annul in IDLE blocks acceptance
        @(negedge clk);
        bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.opdata1_i = 32'd40; bus.opdata2_i = 32'd5;
        #1 check("idle_annul stall", 64'(bus.stall_o), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("idle_annul state", 64'(dut.state_q), 64'(DIV_FREE));
        end
        bus.start_i = 1'b0; bus.annul_i = 1'b0;

        // Annul in cycle 10, then 9/3 issued in cycle 12 completes in cycle 45
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
        ready_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            ready_seen |= bus.ready_o;
        end
        bus.annul_i = 1'b1;
        #1 check("annul stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        ready_seen |= bus.ready_o;
        check("annul state", 64'(dut.state_q), 64'(DIV_FREE));
        check("annul cnt", 64'(dut.cnt_q), 64'd0);
        check("annul ready_never", 64'(ready_seen), 64'd0);
        bus.annul_i = 1'b0; bus.start_i = 1'b0;
        @(negedge clk);
        run_div("post_annul 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // Reset mid-divide in cycle 20
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b1; bus.opdata1_i = 32'hFFFF0000; bus.opdata2_i = 32'd7;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_mid ready", 64'(bus.ready_o), 64'd0);
        check("rst_mid result", bus.result_o, 64'h0);
        check("rst_mid cnt", 64'(dut.cnt_q), 64'd0);
        check("rst_mid state", 64'(dut.state_q), 64'(DIV_FREE));
        check("rst_mid datapath", {dut.dvd_q, dut.rem_q}, 64'h0);
        check("rst_mid stall", 64'(bus.stall_o), 64'd1);
        @(negedge clk);
        bus.start_i = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        run_div("post_reset 1/1", 1'b0, 32'd1, 32'd1, 64'h00000000_00000001);

        // Reset while holding a finished result in END
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        guard = 0;
        while (!bus.ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("end_hold ready", 64'(bus.ready_o), 64'd1);
        resetn = 1'b0;
        #1;
        check("rst_end ready", 64'(bus.ready_o), 64'd0);
        check("rst_end result", bus.result_o, 64'h0);
        @(negedge clk);
        bus.start_i = 1'b0;
        resetn = 1'b1;

        // Randomised requests against the reference
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'h1;
                2:       b = 32'hFFFFFFFF;
                3:       b = 32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            @(negedge clk);
            run_div($sformatf("rand%0d", i), sgn, a, b, model(sgn, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide sequencer for the EX stage: accepts a DIV/DIVU request from the ALU control path, runs a 32-iteration radix-2 restoring division over shared operand/partial-remainder registers, and returns {HI, LO} = {remainder, quotient} for the HI/LO write-back. It raises a pipeline stall while a division is outstanding and honours flushes from the exception/branch logic.

## Interface

- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  divide request; held high by EX until `ready_o` is seen.
- `signed_i`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start_i` in IDLE.
- `annul_i`  in  1  flush of the requesting instruction.
- `opdata1_i`  in  WIDTH  dividend; sampled in IDLE.
- `opdata2_i`  in  WIDTH  divisor; sampled in IDLE.
- `result_o`  out  2*WIDTH  {remainder, quotient}; valid only while `ready_o` = 1, otherwise 0.
- `ready_o`  out  1  result valid (registered).
- `stall_o`  out  1  combinational: `start_i & ~ready_o & ~annul_i`.

## Operation

- States: IDLE, BYZERO, ON, END. The encodings are shared constants.
- **IDLE**
  - If `start_i & ~annul_i` and divisor = 0, go to BYZERO.
  - If `start_i & ~annul_i` and divisor ≠ 0, latch |dividend|, |divisor|, the sign of the quotient (sign1 XOR sign2 when signed) and the sign of the remainder (sign1 when signed), clear `cnt`, and go to ON.
  - For unsigned requests the magnitudes are the raw operands.
- **BYZERO**: load result = 0 and go to END.
- **ON**: perform one restoring step per cycle.
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract the divisor. The quotient bit is 1 if there is no borrow, and the difference is kept.
  - `cnt` increments each step. After step `cnt` = WIDTH-1 completes, apply the sign fix to the quotient and remainder, register `result_o`, and go to END.
- **END**: `ready_o` = 1 and `result_o` is held.
  - When `start_i` = 0, go to IDLE, and clear `ready_o` and `result_o`.
  - If `start_i` stays high, the block remains in END (no re-issue of the same request).
- **Annul**
  - `annul_i` = 1 in BYZERO, ON or END: go to IDLE next edge, clear `ready_o`, `result_o` and `cnt`.
  - `annul_i` in IDLE blocks acceptance.
  - Annul takes priority over every transition except reset.
- **Arithmetic**
  - Magnitude uses two's-complement negate in WIDTH bits. The most negative value negates to itself and is treated as an unsigned 2^(WIDTH-1).
  - Signed −2^31 / −1 gives quotient 0x80000000, remainder 0 (wraps, no trap).
- **Reset**
  - `resetn` low at any time, including mid-operation: state IDLE, `cnt` = 0, `ready_o` = 0, `result_o` = 0, all datapath registers 0.
  - `stall_o` continues to follow its equation.

## Timing

- `start_i` sampled high in IDLE in cycle 0 with nonzero divisor: ON for cycles 1–32, `ready_o` = 1 in cycle 33. Latency is 33 cycles.
- Zero divisor: BYZERO in cycle 1, `ready_o` = 1 in cycle 2.
- `ready_o` and `result_o` stay stable for every cycle in END.
- `stall_o` drops in the same cycle `ready_o` rises, so EX captures `result_o` on that edge.
- After END → IDLE, a new request can be accepted on the following cycle. There is no back-to-back acceptance from END.
- Annul sampled in cycle k: state is IDLE in cycle k+1, and `ready_o` never rises for that request.

## Structure

- The shared defines header carries:
  - state codes `DIV_FREE`, `DIV_BYZERO`, `DIV_ON`, `DIV_END`;
  - `DIV_RESULT_READY` / `DIV_RESULT_NOT_READY`;
  - `DIV_START` / `DIV_STOP`;
  - the `DIV`/`DIVU` function codes and the matching ALU-op encodings that the decoder emits.
- One sub-module, `div_step`: combinational single restoring iteration. Inputs are the partial remainder, the next dividend bit and the divisor. Outputs are the new partial remainder and the quotient bit.

## Test plan

- Unsigned 100 / 7, start in cycle 0: in cycle 33, `ready_o` = 1 and `result_o` = 64'h00000002_0000000E; `stall_o` = 1 in cycles 0–32.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2): `result_o` = 64'hFFFFFFFF_FFFFFFFD.
- 0x80000000 / 0xFFFFFFFF:
  - signed gives 64'h00000000_80000000;
  - unsigned gives 64'h80000000_00000000.
- 5 / 0: `ready_o` = 1 in cycle 2 with `result_o` = 0; `start_i` low in cycle 3 gives IDLE in cycle 4 with `ready_o` = 0.
- Annul:
  - `annul_i` pulsed in cycle 10 of a divide: IDLE in cycle 11, `ready_o` stays 0.
  - A new 9 / 3 started in cycle 12 yields 64'h00000000_00000003 in cycle 45.
- `resetn` asserted low in cycle 20 mid-divide: `ready_o`, `result_o` and `cnt` are immediately 0.
- After reset release, a fresh 1 / 1 completes in 33 cycles with 64'h00000000_00000001.
